armleocpu_ptw: RTL and testbench
================================

ARMLEOCPU_PTW -- requirements
Module: armleocpu_ptw

Interface
REQ-001 The block SHALL have no parameters; Sv32 only: 20-bit VPN, 22-bit PPN, 34-bit physical address.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst_n  input  1  reset; one clock; reset is synchronous and active-low.
REQ-004 satp_ppn  input  22  root page-table PPN, sampled at request acceptance.
REQ-005 resolve_request  input  1  walk request.
REQ-006 resolve_virtual_address  input  20  VPN to translate (vpn1=[19:10], vpn0=[9:0]).
REQ-007 resolve_ack  output  1  request accepted this cycle.
REQ-008 resolve_done  output  1  one-cycle pulse: result valid.
REQ-009 resolve_pagefault  output  1  walk ended in page fault.
REQ-010 resolve_accessfault  output  1  memory error during walk.
REQ-011 resolve_access_bits  output  8  leaf PTE[7:0] (D,A,G,U,X,W,R,V), the TLB accesstag source.
REQ-012 resolve_physical_address  output  22  translated PPN.
REQ-013 mem_read  output  1  PTE read request.
REQ-014 mem_address  output  34  PTE byte address.
REQ-015 mem_waitrequest  input  1  read not accepted this cycle.
REQ-016 mem_readdatavalid  input  1  read data valid.
REQ-017 mem_readdata  input  32  PTE.
REQ-018 mem_response  input  2  00 OKAY, nonzero error; valid with mem_readdatavalid.

Function
REQ-019 FSM states IDLE, ISSUE, WAIT_DATA; registers level (1 bit), table_base (22), vpn (20).
REQ-020 resolve_ack SHALL equal (state==IDLE && resolve_request); on ack, latch vpn, table_base=satp_ppn, level=1, go ISSUE.
REQ-021 Requests outside IDLE SHALL be ignored (ack low, no state change).
REQ-022 ISSUE: mem_read=1, mem_address={table_base, level?vpn[19:10]:vpn[9:0], 2'b00}; address SHALL stay stable while mem_waitrequest=1; on !mem_waitrequest go WAIT_DATA.
REQ-023 mem_read SHALL be 0 in IDLE and WAIT_DATA; at most one outstanding read.
REQ-024 mem_readdatavalid SHALL be ignored outside WAIT_DATA.
REQ-025 WAIT_DATA on mem_readdatavalid, priority order: mem_response!=0 -> accessfault; PTE.V=0 or (R=0,W=1) -> pagefault; leaf (R|X) with level=1 and PTE[19:10]!=0 -> pagefault; leaf -> success; non-leaf at level=0 -> pagefault; non-leaf at level=1 -> table_base=PTE[31:10], level=0, go ISSUE.
REQ-026 Success PPN: level=1 -> {PTE[31:20], vpn[9:0]}; level=0 -> PTE[31:10]; access_bits=PTE[7:0].
REQ-027 All result outputs SHALL be registered: resolve_done high exactly one cycle after the terminating readdatavalid cycle, FSM in IDLE that same cycle.
REQ-028 pagefault and accessfault SHALL be mutually exclusive; on any fault physical_address and access_bits SHALL be 0.
REQ-029 Result outputs SHALL hold their value until the next resolve_done; done SHALL be 0 otherwise.
REQ-030 Minimum latency (no waitrequest, data next cycle): ack cycle 0, mem_read accepted cycle 1, data cycle 2, done cycle 3; two-level walk adds 2 cycles.
REQ-031 A/D bits SHALL NOT be updated by the walker; they are passed through for the downstream permission check.

Reset
REQ-032 rst_n=0 at a clock edge SHALL force state=IDLE, level=1, table_base=0, vpn=0 and all outputs 0 (mem_read, resolve_done, faults, access_bits, physical_address, mem_address).
REQ-033 Reset mid-walk SHALL abort without resolve_done; a late readdatavalid after reset SHALL be ignored.
REQ-034 resolve_ack SHALL be 0 while rst_n=0.

Verification
REQ-035 Superpage: satp_ppn=0x00010, VPN=0x12345, PTE@0x10120=0x200000CF -> one read, done, PPN=0x80345, bits=0xCF, faults 0.
REQ-036 Two-level: PTE@0x10120=0x00004001, PTE@0x10D14=0x0ABCD0DF -> reads 0x10120 then 0x10D14, PPN=0x2AF34, bits=0xDF.
REQ-037 Misaligned superpage PTE=0x00000C0F at level 1 -> pagefault=1, no second read; V=0 PTE=0x0 -> pagefault=1; non-leaf at level 0 -> pagefault=1.
REQ-038 mem_response=2'b10 on first read -> accessfault=1, pagefault=0, PPN=0.
REQ-039 mem_waitrequest held 5 cycles -> mem_address/mem_read stable throughout; resolve_request asserted mid-walk -> ack stays 0.
REQ-040 rst_n low while in WAIT_DATA, then readdatavalid -> no done, state IDLE, next request walks normally.

Source files
------------

// File: rtl/armleocpu_ptw.sv
// Sv32 hardware page-table walker: resolves a 20-bit VPN to a 22-bit PPN
// by reading at most two PTEs, reporting page/access faults on failure.
module armleocpu_ptw (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [21:0] satp_ppn,
  input  logic        resolve_request,
  input  logic [19:0] resolve_virtual_address,
  output logic        resolve_ack,
  output logic        resolve_done,
  output logic        resolve_pagefault,
  output logic        resolve_accessfault,
  output logic [7:0]  resolve_access_bits,
  output logic [21:0] resolve_physical_address,
  output logic        mem_read,
  output logic [33:0] mem_address,
  input  logic        mem_waitrequest,
  input  logic        mem_readdatavalid,
  input  logic [31:0] mem_readdata,
  input  logic [1:0]  mem_response
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DATA} state_t;
  typedef enum logic [1:0] {O_ACCESS, O_PAGE, O_LEAF, O_DESCEND} outcome_t;

  state_t      state;
  logic        level;
  logic [21:0] table_base;
  logic [19:0] vpn;
  outcome_t    outcome;

  // RSW bits carry no meaning for the walker.
  logic unused_rsw;
  assign unused_rsw = ^mem_readdata[9:8];

  // No acceptance while held in reset so the requester never sees a phantom ack.
  assign resolve_ack = rst_n && (state == IDLE) && resolve_request;
  assign mem_read    = (state == ISSUE);
  assign mem_address = {table_base, (level ? vpn[19:10] : vpn[9:0]), 2'b00};

  // Classify the returned PTE; first matching rule wins.
  always_comb begin
    logic v, r, w, x;
    v = mem_readdata[0];
    r = mem_readdata[1];
    w = mem_readdata[2];
    x = mem_readdata[3];
    outcome = O_DESCEND;
    if (mem_response != 2'b00)
      outcome = O_ACCESS;
    else if (!v || (!r && w))
      outcome = O_PAGE;
    else if ((r || x) && level && (mem_readdata[19:10] != 10'd0))
      outcome = O_PAGE;       // misaligned superpage
    else if (r || x)
      outcome = O_LEAF;
    else if (!level)
      outcome = O_PAGE;       // pointer PTE at the last level
    else
      outcome = O_DESCEND;
  end

  // Walk FSM with registered result outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state                    <= IDLE;
      level                    <= 1'b1;
      table_base               <= '0;
      vpn                      <= '0;
      resolve_done             <= 1'b0;
      resolve_pagefault        <= 1'b0;
      resolve_accessfault      <= 1'b0;
      resolve_access_bits      <= '0;
      resolve_physical_address <= '0;
    end else begin
      resolve_done <= 1'b0;
      case (state)
        IDLE: if (resolve_request) begin
          vpn        <= resolve_virtual_address;
          table_base <= satp_ppn;
          level      <= 1'b1;
          state      <= ISSUE;
        end
        ISSUE: if (!mem_waitrequest) state <= WAIT_DATA;
        WAIT_DATA: if (mem_readdatavalid) begin
          if (outcome == O_DESCEND) begin
            table_base <= mem_readdata[31:10];
            level      <= 1'b0;
            state      <= ISSUE;
          end else begin
            state                    <= IDLE;
            resolve_done             <= 1'b1;
            resolve_accessfault      <= (outcome == O_ACCESS);
            resolve_pagefault        <= (outcome == O_PAGE);
            resolve_access_bits      <= '0;
            resolve_physical_address <= '0;
            if (outcome == O_LEAF) begin
              resolve_access_bits      <= mem_readdata[7:0];
              resolve_physical_address <= level ? {mem_readdata[31:20], vpn[9:0]}
                                                : mem_readdata[31:10];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_armleocpu_ptw.sv
// Directed bench for the Sv32 walker: table of walks plus stall/reset sequences.
module tb_armleocpu_ptw;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [21:0] satp_ppn;
  logic        resolve_request;
  logic [19:0] resolve_virtual_address;
  logic        resolve_ack, resolve_done, resolve_pagefault, resolve_accessfault;
  logic [7:0]  resolve_access_bits;
  logic [21:0] resolve_physical_address;
  logic        mem_read;
  logic [33:0] mem_address;
  logic        mem_waitrequest, mem_readdatavalid;
  logic [31:0] mem_readdata;
  logic [1:0]  mem_response;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  armleocpu_ptw dut (
    .clk(clk), .rst_n(rst_n), .satp_ppn(satp_ppn),
    .resolve_request(resolve_request),
    .resolve_virtual_address(resolve_virtual_address),
    .resolve_ack(resolve_ack), .resolve_done(resolve_done),
    .resolve_pagefault(resolve_pagefault),
    .resolve_accessfault(resolve_accessfault),
    .resolve_access_bits(resolve_access_bits),
    .resolve_physical_address(resolve_physical_address),
    .mem_read(mem_read), .mem_address(mem_address),
    .mem_waitrequest(mem_waitrequest), .mem_readdatavalid(mem_readdatavalid),
    .mem_readdata(mem_readdata), .mem_response(mem_response)
  );

  typedef struct {
    logic [21:0] satp;
    logic [19:0] vpn;
    int          nreads;
    logic [33:0] addr0, addr1;
    logic [31:0] pte0, pte1;
    logic [1:0]  resp0, resp1;
    logic        pf, af;
    logic [21:0] ppn;
    logic [7:0]  bits;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [21:0] satp, logic [19:0] vpn, int n,
                              logic [33:0] a0, logic [33:0] a1,
                              logic [31:0] p0, logic [31:0] p1,
                              logic [1:0] r0, logic [1:0] r1,
                              logic pf, logic af, logic [21:0] ppn, logic [7:0] bits);
    vec_t v;
    v.satp = satp; v.vpn = vpn; v.nreads = n;
    v.addr0 = a0; v.addr1 = a1; v.pte0 = p0; v.pte1 = p1;
    v.resp0 = r0; v.resp1 = r1; v.pf = pf; v.af = af; v.ppn = ppn; v.bits = bits;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Full walk with no stalls; inputs driven and outputs sampled at negedge.
  task automatic walk(input vec_t v, input int idx);
    logic [33:0] a;
    logic [31:0] p;
    logic [1:0]  r;
    string       tag;
    tag = $sformatf("v%0d", idx);
    resolve_request = 1'b1;
    satp_ppn = v.satp;
    resolve_virtual_address = v.vpn;
    #1 chk({tag, " ack"}, resolve_ack, 1);
    tick();
    resolve_request = 1'b0;
    satp_ppn = '0;
    resolve_virtual_address = '0;
    for (int k = 0; k < v.nreads; k++) begin
      a = (k == 0) ? v.addr0 : v.addr1;
      p = (k == 0) ? v.pte0  : v.pte1;
      r = (k == 0) ? v.resp0 : v.resp1;
      chk($sformatf("%s read%0d mem_read", tag, k), mem_read, 1);
      chk($sformatf("%s read%0d addr", tag, k), mem_address, a);
      tick();
      chk($sformatf("%s read%0d wait mem_read", tag, k), mem_read, 0);
      chk($sformatf("%s read%0d early done", tag, k), resolve_done, 0);
      mem_readdatavalid = 1'b1;
      mem_readdata = p;
      mem_response = r;
      tick();
      mem_readdatavalid = 1'b0;
      mem_readdata = '0;
      mem_response = '0;
    end
    chk({tag, " done"}, resolve_done, 1);
    chk({tag, " pf"}, resolve_pagefault, v.pf);
    chk({tag, " af"}, resolve_accessfault, v.af);
    chk({tag, " ppn"}, resolve_physical_address, v.ppn);
    chk({tag, " bits"}, resolve_access_bits, v.bits);
    chk({tag, " no extra read"}, mem_read, 0);
    tick();
    chk({tag, " done pulse"}, resolve_done, 0);
    chk({tag, " ppn hold"}, resolve_physical_address, v.ppn);
    chk({tag, " bits hold"}, resolve_access_bits, v.bits);
  endtask

  initial begin
    rst_n = 1'b0;
    satp_ppn = '0;
    resolve_request = 1'b0;
    resolve_virtual_address = '0;
    mem_waitrequest = 1'b0;
    mem_readdatavalid = 1'b0;
    mem_readdata = '0;
    mem_response = '0;

    //        satp      vpn      n  addr0       addr1       pte0          pte1          r0    r1    pf af ppn        bits
    vecs.push_back(mk(22'h10, 20'h12345, 1, 34'h10120, 34'h0,     32'h200000CF, 32'h0,        2'b00, 2'b00, 0, 0, 22'h80345, 8'hCF));
    vecs.push_back(mk(22'h10, 20'h12345, 2, 34'h10120, 34'h10D14, 32'h00004001, 32'h0ABCD0DF, 2'b00, 2'b00, 0, 0, 22'h2AF34, 8'hDF));
    vecs.push_back(mk(22'h10, 20'h12345, 1, 34'h10120, 34'h0,     32'h00000C0F, 32'h0,        2'b00, 2'b00, 1, 0, 22'h0,     8'h00));
    vecs.push_back(mk(22'h10, 20'h12345, 1, 34'h10120, 34'h0,     32'h00000000, 32'h0,        2'b00, 2'b00, 1, 0, 22'h0,     8'h00));
    vecs.push_back(mk(22'h10, 20'h12345, 2, 34'h10120, 34'h10D14, 32'h00004001, 32'h00004001, 2'b00, 2'b00, 1, 0, 22'h0,     8'h00));
    vecs.push_back(mk(22'h10, 20'h12345, 1, 34'h10120, 34'h0,     32'h200000CF, 32'h0,        2'b10, 2'b00, 0, 1, 22'h0,     8'h00));
    vecs.push_back(mk(22'h10, 20'h12345, 1, 34'h10120, 34'h0,     32'h00000005, 32'h0,        2'b00, 2'b00, 1, 0, 22'h0,     8'h00));
    vecs.push_back(mk(22'h10, 20'h12345, 2, 34'h10120, 34'h10D14, 32'h00004001, 32'h0ABCD0DF, 2'b00, 2'b01, 0, 1, 22'h0,     8'h00));
    vecs.push_back(mk(22'h1,  20'hFFFFF, 2, 34'h1FFC,  34'h1FFC,  32'h00000401, 32'hFFFFFC0B, 2'b00, 2'b00, 0, 0, 22'h3FFFFF, 8'h0B));

    // Reset state, with a request pending that must not be acked.
    @(negedge clk);
    resolve_request = 1'b1;
    tick();
    #1 chk("rst ack", resolve_ack, 0);
    chk("rst mem_read", mem_read, 0);
    chk("rst mem_address", mem_address, 0);
    chk("rst done", resolve_done, 0);
    chk("rst pf", resolve_pagefault, 0);
    chk("rst af", resolve_accessfault, 0);
    chk("rst bits", resolve_access_bits, 0);
    chk("rst ppn", resolve_physical_address, 0);
    resolve_request = 1'b0;
    rst_n = 1'b1;
    tick();

    // Stray readdatavalid in IDLE must be ignored.
    mem_readdatavalid = 1'b1;
    mem_readdata = 32'h200000CF;
    tick();
    mem_readdatavalid = 1'b0;
    mem_readdata = '0;
    chk("idle rdv done", resolve_done, 0);
    chk("idle rdv mem_read", mem_read, 0);

    foreach (vecs[i]) walk(vecs[i], i);

    // Waitrequest stall for 5 cycles with a mid-walk request.
    resolve_request = 1'b1;
    satp_ppn = 22'h10;
    resolve_virtual_address = 20'h12345;
    #1 chk("stall ack", resolve_ack, 1);
    tick();
    satp_ppn = 22'h3FFFFF;
    resolve_virtual_address = 20'hFFFFF;
    mem_waitrequest = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("stall c%0d mem_read", c), mem_read, 1);
      chk($sformatf("stall c%0d addr", c), mem_address, 34'h10120);
      chk($sformatf("stall c%0d ack", c), resolve_ack, 0);
      tick();
    end
    mem_waitrequest = 1'b0;
    #1 chk("stall release addr", mem_address, 34'h10120);
    chk("stall release ack", resolve_ack, 0);
    tick();
    chk("stall wait mem_read", mem_read, 0);
    chk("stall wait ack", resolve_ack, 0);
    resolve_request = 1'b0;
    mem_readdatavalid = 1'b1;
    mem_readdata = 32'h200000CF;
    tick();
    mem_readdatavalid = 1'b0;
    mem_readdata = '0;
    chk("stall done", resolve_done, 1);
    chk("stall ppn", resolve_physical_address, 22'h80345);
    chk("stall bits", resolve_access_bits, 8'hCF);
    tick();

    // Reset while in WAIT_DATA, then a late readdatavalid.
    resolve_request = 1'b1;
    satp_ppn = 22'h10;
    resolve_virtual_address = 20'h12345;
    tick();
    resolve_request = 1'b0;
    tick();
    chk("abort in wait", mem_read, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    mem_readdatavalid = 1'b1;
    mem_readdata = 32'h200000CF;
    tick();
    mem_readdatavalid = 1'b0;
    mem_readdata = '0;
    chk("abort done", resolve_done, 0);
    chk("abort mem_read", mem_read, 0);
    chk("abort ppn", resolve_physical_address, 0);
    tick();
    chk("abort done late", resolve_done, 0);
    walk(vecs[1], 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Hard time limit so the bench cannot hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1);
  end

endmodule
